// File: rtl/dht_sensor_ctrl.sv
// Single-wire DHT11/DHT22 controller: start pulse, response/bit timing, 40-bit frame capture.
// Define DHT_CHECKSUM_EN to reject frames whose byte4 is not the byte sum of bytes 0..3.
module dht_sensor_ctrl #(
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned RELEASE_US    = 30,
  parameter int unsigned BIT_THRESH_US = 40,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned HOLDOFF_US    = 1000000
) (
  input  logic        clk1mhz,
  input  logic        rst_n,
  input  logic        start,
  inout  wire         dht_dat,
  output logic        busy,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] hum,
  output logic [15:0] temp,
  output logic [3:0]  state_dbg
);

  localparam logic [19:0] START_LAST   = 20'(START_LOW_US - 1);
  localparam logic [19:0] RELEASE_LAST = 20'(RELEASE_US - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_US - 1);
  localparam logic [19:0] HOLDOFF_LAST = 20'(HOLDOFF_US - 1);
  localparam logic [19:0] BIT_THRESH   = 20'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RELEASE   = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_RESP_END  = 4'd5,
    S_BIT_LOW   = 4'd6,
    S_BIT_HIGH  = 4'd7,
    S_CHECK     = 4'd8,
    S_HOLDOFF   = 4'd9
  } state_t;

`ifdef DHT_CHECKSUM_EN
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (sum == frame[7:0]);
  endfunction
`endif

  state_t      state_r;
  state_t      next_s;
  logic [19:0] cnt_r;
  logic [5:0]  bit_cnt_r;
  logic [39:0] shift_r;
  logic        line_meta_r;
  logic        line_r;
  logic        drive_low_r;
  logic        busy_r;
  logic        valid_r;
  logic        err_r;
  logic [1:0]  err_code_r;
  logic [15:0] hum_r;
  logic [15:0] temp_r;
  logic        set_valid_s;
  logic        set_err_s;
  logic [1:0]  err_code_s;
  logic        shift_en_s;
  logic        frame_ok_s;

  // Open-drain pad: the controller only ever pulls low or lets go
  assign dht_dat   = drive_low_r ? 1'b0 : 1'bz;
  assign busy      = busy_r;
  assign valid     = valid_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign hum       = hum_r;
  assign temp      = temp_r;
  assign state_dbg = state_r;

`ifdef DHT_CHECKSUM_EN
  assign frame_ok_s = checksum_ok(shift_r);
`else
  assign frame_ok_s = 1'b1;
`endif

  // Two-flop synchronizer; idles high like the pulled-up line
  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      line_meta_r <= 1'b1;
      line_r      <= 1'b1;
    end else begin
      line_meta_r <= dht_dat;
      line_r      <= line_meta_r;
    end
  end

  // State register and dwell counter, cleared on every state entry
  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 20'd0;
    end else begin
      state_r <= next_s;
      if ((next_s != state_r) || (state_r == S_IDLE)) begin
        cnt_r <= 20'd0;
      end else begin
        cnt_r <= cnt_r + 20'd1;
      end
    end
  end

  // Next-state decode; an edge seen in the timeout cycle takes priority
  always_comb begin
    next_s      = state_r;
    set_valid_s = 1'b0;
    set_err_s   = 1'b0;
    err_code_s  = 2'd0;
    shift_en_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) next_s = S_START_LOW;
        else       next_s = S_IDLE;
      end
      S_START_LOW: begin
        if (cnt_r == START_LAST) next_s = S_RELEASE;
        else                     next_s = S_START_LOW;
      end
      S_RELEASE: begin
        if (cnt_r == RELEASE_LAST) next_s = S_RESP_LOW;
        else                       next_s = S_RELEASE;
      end
      S_RESP_LOW, S_RESP_HIGH, S_RESP_END: begin
        if ((state_r == S_RESP_HIGH) ? line_r : !line_r) begin
          if (state_r == S_RESP_LOW)       next_s = S_RESP_HIGH;
          else if (state_r == S_RESP_HIGH) next_s = S_RESP_END;
          else                             next_s = S_BIT_LOW;
        end else if (cnt_r == TIMEOUT_LAST) begin
          next_s     = S_HOLDOFF;
          set_err_s  = 1'b1;
          err_code_s = 2'd1;
        end else begin
          next_s = state_r;
        end
      end
      S_BIT_LOW: begin
        if (line_r) begin
          next_s = S_BIT_HIGH;
        end else if (cnt_r == TIMEOUT_LAST) begin
          next_s     = S_HOLDOFF;
          set_err_s  = 1'b1;
          err_code_s = 2'd2;
        end else begin
          next_s = S_BIT_LOW;
        end
      end
      S_BIT_HIGH: begin
        if (!line_r) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == 6'd39) next_s = S_CHECK;
          else                    next_s = S_BIT_LOW;
        end else if (cnt_r == TIMEOUT_LAST) begin
          next_s     = S_HOLDOFF;
          set_err_s  = 1'b1;
          err_code_s = 2'd2;
        end else begin
          next_s = S_BIT_HIGH;
        end
      end
      S_CHECK: begin
        next_s = S_HOLDOFF;
        if (frame_ok_s) begin
          set_valid_s = 1'b1;
        end else begin
          set_err_s  = 1'b1;
          err_code_s = 2'd3;
        end
      end
      S_HOLDOFF: begin
        if (cnt_r == HOLDOFF_LAST) next_s = S_IDLE;
        else                       next_s = S_HOLDOFF;
      end
      default: begin
        next_s = S_IDLE;
      end
    endcase
  end

  // Frame shift register, MSB first; bit is '1' when the high time exceeds the threshold
  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= 40'd0;
      bit_cnt_r <= 6'd0;
    end else if ((state_r == S_IDLE) && start) begin
      shift_r   <= 40'd0;
      bit_cnt_r <= 6'd0;
    end else if (shift_en_s) begin
      shift_r   <= {shift_r[38:0], (cnt_r > BIT_THRESH)};
      bit_cnt_r <= bit_cnt_r + 6'd1;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered outputs, all derived from the decoded next state
  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      drive_low_r <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'd0;
      hum_r       <= 16'd0;
      temp_r      <= 16'd0;
    end else begin
      drive_low_r <= (next_s == S_START_LOW);
      busy_r      <= (next_s != S_IDLE);
      valid_r     <= set_valid_s;
      err_r       <= set_err_s;
      if (set_err_s) begin
        err_code_r <= err_code_s;
      end
      if (set_valid_s) begin
        hum_r  <= shift_r[39:24];
        temp_r <= shift_r[23:8];
      end
    end
  end

endmodule
